// File: rtl/axi_master128_cmd_if.sv
// rtl/axi_master128_cmd_if.sv - command, stream and AXI signal bundle for axi_master128_cmd
interface axi_master128_cmd_if;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [39:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic         wd_valid, wd_ready;
  logic [127:0] wd_data;
  logic [15:0]  wd_strb;
  logic         rd_valid, rd_ready, rd_last;
  logic [127:0] rd_data;
  logic         done_pulse, done_err;
  logic [39:0]  araddr_m0, awaddr_m0;
  logic [7:0]   arid_m0, arlen_m0, awid_m0, awlen_m0;
  logic [2:0]   arsize_m0, arprot_m0, awsize_m0, awprot_m0;
  logic [1:0]   arburst_m0, awburst_m0;
  logic [3:0]   arcache_m0, awcache_m0;
  logic         arvalid_m0, arready_m0, awvalid_m0, awready_m0;
  logic [127:0] wdata_m0, rdata_m0;
  logic [15:0]  wstrb_m0;
  logic [7:0]   wid_m0, bid_m0, rid_m0;
  logic         wlast_m0, wvalid_m0, wready_m0;
  logic [1:0]   bresp_m0, rresp_m0;
  logic         bvalid_m0, bready_m0, rlast_m0, rvalid_m0, rready_m0;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, output cmd_ready,
    input  wd_valid, wd_data, wd_strb, output wd_ready,
    input  rd_ready, output rd_valid, rd_data, rd_last,
    output done_pulse, done_err,
    output araddr_m0, arid_m0, arlen_m0, arsize_m0, arburst_m0, arcache_m0, arprot_m0, arvalid_m0,
    input  arready_m0,
    output awaddr_m0, awid_m0, awlen_m0, awsize_m0, awburst_m0, awcache_m0, awprot_m0, awvalid_m0,
    input  awready_m0,
    output wdata_m0, wstrb_m0, wid_m0, wlast_m0, wvalid_m0, input wready_m0,
    input  bid_m0, bresp_m0, bvalid_m0, output bready_m0,
    input  rdata_m0, rid_m0, rresp_m0, rlast_m0, rvalid_m0, output rready_m0
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, input cmd_ready,
    output wd_valid, wd_data, wd_strb, input wd_ready,
    output rd_ready, input rd_valid, rd_data, rd_last,
    input  done_pulse, done_err,
    input  araddr_m0, arid_m0, arlen_m0, arsize_m0, arburst_m0, arcache_m0, arprot_m0, arvalid_m0,
    output arready_m0,
    input  awaddr_m0, awid_m0, awlen_m0, awsize_m0, awburst_m0, awcache_m0, awprot_m0, awvalid_m0,
    output awready_m0,
    input  wdata_m0, wstrb_m0, wid_m0, wlast_m0, wvalid_m0, output wready_m0,
    output bid_m0, bresp_m0, bvalid_m0, input bready_m0,
    output rdata_m0, rid_m0, rresp_m0, rlast_m0, rvalid_m0, input rready_m0
  );
endinterface

// File: rtl/axi_master128_cmd.sv
// rtl/axi_master128_cmd.sv - single-outstanding 128-bit AXI master turning commands into one INCR burst
// Define AXI_MASTER_4K_CHECK_EN to reject commands whose burst crosses a 4 KB boundary.
module axi_master128_cmd #(
  parameter logic [7:0] AXI_ID    = 8'h00,
  parameter logic [3:0] AXI_CACHE = 4'h3
) (
  input  logic                pll_core_cpuclk,
  input  logic                pad_cpu_rst_b,
  axi_master128_cmd_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  state_t      state_q;
  logic [35:0] addr_q;
  logic [7:0]  len_q, cnt_q;
  logic        err_q, cmd_ready_q, arvalid_q, awvalid_q, bready_q;
  logic        done_pulse_q, done_err_q;

  logic is_last, r_hs, w_hs, r_err, b_err, cross_4k;
  logic unused_addr_lsbs;

  assign is_last = (cnt_q == len_q);
  assign r_hs    = (state_q == S_R) && bus.rvalid_m0 && bus.rd_ready;
  assign w_hs    = (state_q == S_W) && bus.wd_valid && bus.wready_m0;
  assign r_err   = (bus.rresp_m0 != 2'b00) || (bus.rid_m0 != AXI_ID) || (bus.rlast_m0 != is_last);
  assign b_err   = (bus.bresp_m0 != 2'b00) || (bus.bid_m0 != AXI_ID);
  assign unused_addr_lsbs = ^bus.cmd_addr[3:0];

`ifdef AXI_MASTER_4K_CHECK_EN
  assign cross_4k = ({1'b0, bus.cmd_addr[11:4]} + {1'b0, bus.cmd_len}) > 9'd255;
`else
  assign cross_4k = 1'b0;
`endif

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_pulse_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_q <= 1'b0;
          addr_q      <= bus.cmd_addr[39:4];
          len_q       <= bus.cmd_len;
          if (cross_4k) begin
            state_q      <= S_DONE;
            done_pulse_q <= 1'b1;
            done_err_q   <= 1'b1;
          end else if (bus.cmd_write) begin
            state_q   <= S_AW;
            awvalid_q <= 1'b1;
          end else begin
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
          end
        end
        S_AR: if (bus.arready_m0) begin
          arvalid_q <= 1'b0;
          state_q   <= S_R;
        end
        S_R: if (r_hs) begin
          err_q <= err_q | r_err;
          if (is_last) begin
            state_q      <= S_DONE;
            done_pulse_q <= 1'b1;
            done_err_q   <= err_q | r_err;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_AW: if (bus.awready_m0) begin
          awvalid_q <= 1'b0;
          state_q   <= S_W;
        end
        S_W: if (w_hs) begin
          if (is_last) begin
            state_q  <= S_B;
            bready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_B: if (bus.bvalid_m0) begin
          bready_q     <= 1'b0;
          err_q        <= err_q | b_err;
          state_q      <= S_DONE;
          done_pulse_q <= 1'b1;
          done_err_q   <= err_q | b_err;
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          done_pulse_q <= 1'b0;
          done_err_q   <= 1'b0;
          err_q        <= 1'b0;
          cnt_q        <= '0;
          cmd_ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.done_pulse = done_pulse_q;
  assign bus.done_err   = done_err_q;

  // Address channels carry only registered fields, so payload is stable while valid.
  assign bus.araddr_m0  = {addr_q, 4'h0};
  assign bus.arid_m0    = AXI_ID;
  assign bus.arlen_m0   = len_q;
  assign bus.arsize_m0  = 3'b100;
  assign bus.arburst_m0 = 2'b01;
  assign bus.arcache_m0 = AXI_CACHE;
  assign bus.arprot_m0  = 3'b000;
  assign bus.arvalid_m0 = arvalid_q;
  assign bus.awaddr_m0  = {addr_q, 4'h0};
  assign bus.awid_m0    = AXI_ID;
  assign bus.awlen_m0   = len_q;
  assign bus.awsize_m0  = 3'b100;
  assign bus.awburst_m0 = 2'b01;
  assign bus.awcache_m0 = AXI_CACHE;
  assign bus.awprot_m0  = 3'b000;
  assign bus.awvalid_m0 = awvalid_q;

  // Data channels pass straight through, but only while the matching data state is active.
  assign bus.wdata_m0   = bus.wd_data;
  assign bus.wstrb_m0   = bus.wd_strb;
  assign bus.wid_m0     = AXI_ID;
  assign bus.wvalid_m0  = (state_q == S_W) && bus.wd_valid;
  assign bus.wd_ready   = (state_q == S_W) && bus.wready_m0;
  assign bus.wlast_m0   = (state_q == S_W) && is_last;
  assign bus.bready_m0  = bready_q;
  assign bus.rready_m0  = (state_q == S_R) && bus.rd_ready;
  assign bus.rd_valid   = (state_q == S_R) && bus.rvalid_m0;
  assign bus.rd_data    = bus.rdata_m0;
  assign bus.rd_last    = (state_q == S_R) && bus.rlast_m0;
endmodule

// File: tb/tb_axi_master128_cmd.sv
// tb/tb_axi_master128_cmd.sv - directed scoreboard bench for axi_master128_cmd with a behavioural AXI memory slave
module tb_axi_master128_cmd;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_master128_cmd_if bus ();
  axi_master128_cmd dut (.pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  logic done_err_cap = 1'b0;
  logic [1:0] bresp_knob, rresp_knob;

  logic [128:0] exp_q[$];
  logic [128:0] rx_q[$];
  logic [47:0]  ar_q[$];
  logic [47:0]  aw_q[$];
  logic         wl_q[$];
  logic [127:0] mem [logic [35:0]];
  logic [127:0] ref_mem [logic [35:0]];

  function automatic logic [127:0] dflt(input logic [35:0] a);
    return {4{~a[31:0]}};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw, input logic [15:0] strb);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] mem_rd(input logic [35:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [127:0] ref_rd(input logic [35:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Behavioural slave memory: one read and one write burst at a time.
  logic        sl_rbusy, sl_wbusy, sl_bpend;
  logic [35:0] sl_rbase, sl_wbase;
  logic [7:0]  sl_rlen, sl_rbeat, sl_wbeat;
  logic [127:0] sl_rdata;

  assign bus.arready_m0 = !sl_rbusy;
  assign bus.rvalid_m0  = sl_rbusy;
  assign bus.rdata_m0   = sl_rdata;
  assign bus.rlast_m0   = sl_rbusy && (sl_rbeat == sl_rlen);
  assign bus.rid_m0     = 8'h00;
  assign bus.rresp_m0   = rresp_knob;
  assign bus.awready_m0 = !sl_wbusy && !sl_bpend;
  assign bus.wready_m0  = sl_wbusy;
  assign bus.bvalid_m0  = sl_bpend;
  assign bus.bid_m0     = 8'h00;
  assign bus.bresp_m0   = bresp_knob;

  always @(posedge clk) begin
    if (!rst_n) begin
      sl_rbusy <= 1'b0;
      sl_wbusy <= 1'b0;
      sl_bpend <= 1'b0;
      sl_rbeat <= 8'd0;
      sl_rlen  <= 8'd0;
      sl_rdata <= '0;
    end else begin
      if (bus.arvalid_m0 && bus.arready_m0) begin
        sl_rbusy <= 1'b1;
        sl_rbase <= bus.araddr_m0[39:4];
        sl_rlen  <= bus.arlen_m0;
        sl_rbeat <= 8'd0;
        sl_rdata <= mem_rd(bus.araddr_m0[39:4]);
        ar_q.push_back({bus.araddr_m0, bus.arlen_m0});
      end
      if (bus.rvalid_m0 && bus.rready_m0) begin
        if (sl_rbeat == sl_rlen) sl_rbusy <= 1'b0;
        else begin
          sl_rbeat <= sl_rbeat + 8'd1;
          sl_rdata <= mem_rd(sl_rbase + 36'(sl_rbeat) + 36'd1);
        end
      end
      if (bus.awvalid_m0 && bus.awready_m0) begin
        sl_wbusy <= 1'b1;
        sl_wbase <= bus.awaddr_m0[39:4];
        sl_wbeat <= 8'd0;
        aw_q.push_back({bus.awaddr_m0, bus.awlen_m0});
      end
      if (bus.wvalid_m0 && bus.wready_m0) begin
        mem[sl_wbase + 36'(sl_wbeat)] = merge(mem_rd(sl_wbase + 36'(sl_wbeat)), bus.wdata_m0, bus.wstrb_m0);
        wl_q.push_back(bus.wlast_m0);
        sl_wbeat <= sl_wbeat + 8'd1;
        if (bus.wlast_m0) begin
          sl_wbusy <= 1'b0;
          sl_bpend <= 1'b1;
        end
      end
      if (bus.bvalid_m0 && bus.bready_m0) sl_bpend <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid && bus.rd_ready) rx_q.push_back({bus.rd_last, bus.rd_data});
      if (bus.done_pulse) begin
        done_cnt     <= done_cnt + 1;
        done_err_cap <= bus.done_err;
      end
    end
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic wr, input logic [39:0] addr, input logic [7:0] len);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    check("cmd_ready_idle", 160'(bus.cmd_ready), 160'(1));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("cmd_ready_busy", 160'(bus.cmd_ready), 160'(0));
  endtask

  task automatic do_read(input logic [39:0] addr, input logic [7:0] len, input bit toggle, input bit exp_err);
    int start;
    logic [128:0] got, want;
    logic [47:0] arc;
    start = done_cnt;
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back({(i == int'(len)), ref_rd(addr[39:4] + 36'(i))});
    send_cmd(1'b0, addr, len);
    check("arvalid_lat", 160'(bus.arvalid_m0), 160'(1));
    check("ar_const", 160'({bus.arsize_m0, bus.arburst_m0, bus.arcache_m0, bus.arprot_m0, bus.arid_m0}),
          160'({3'b100, 2'b01, 4'h3, 3'b000, 8'h00}));
    for (int c = 0; c < 400 && done_cnt == start; c++) begin
      @(negedge clk);
      if (toggle) bus.rd_ready = ~bus.rd_ready;
    end
    bus.rd_ready = 1'b1;
    check("rd_done_seen", 160'(done_cnt), 160'(start + 1));
    check("rd_done_err", 160'(done_err_cap), 160'(exp_err));
    check("ar_issued", 160'(ar_q.size()), 160'(1));
    if (ar_q.size() > 0) begin
      arc = ar_q.pop_front();
      check("ar_addr_len", 160'(arc), 160'({addr[39:4], 4'h0, len}));
    end
    check("rd_count", 160'(rx_q.size()), 160'(exp_q.size()));
    while (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("rd_beat", 160'(got), 160'(want));
      end
    end
    exp_q.delete();
  endtask

  task automatic do_write(input logic [39:0] addr, input logic [7:0] len, input logic [15:0] strb,
                          input bit seq, input bit exp_err);
    int start, i;
    logic [127:0] d;
    logic [47:0] awc;
    logic wl;
    start = done_cnt;
    send_cmd(1'b1, addr, len);
    check("awvalid_lat", 160'(bus.awvalid_m0), 160'(1));
    check("aw_const", 160'({bus.awsize_m0, bus.awburst_m0, bus.awcache_m0, bus.awprot_m0, bus.awid_m0}),
          160'({3'b100, 2'b01, 4'h3, 3'b000, 8'h00}));
    for (int b = 0; b <= int'(len); b++) begin
      d = seq ? 128'(b) : {$urandom(), $urandom(), $urandom(), $urandom()};
      ref_mem[addr[39:4] + 36'(b)] = merge(ref_rd(addr[39:4] + 36'(b)), d, strb);
      bus.wd_valid = 1'b1;
      bus.wd_data  = d;
      bus.wd_strb  = strb;
      for (int c = 0; c < 100 && !bus.wd_ready; c++) @(negedge clk);
      check("wd_ready", 160'(bus.wd_ready), 160'(1));
      @(negedge clk);
    end
    bus.wd_valid = 1'b0;
    for (int c = 0; c < 100 && done_cnt == start; c++) @(negedge clk);
    check("wr_done_seen", 160'(done_cnt), 160'(start + 1));
    check("wr_done_err", 160'(done_err_cap), 160'(exp_err));
    check("aw_issued", 160'(aw_q.size()), 160'(1));
    if (aw_q.size() > 0) begin
      awc = aw_q.pop_front();
      check("aw_addr_len", 160'(awc), 160'({addr[39:4], 4'h0, len}));
    end
    check("wlast_count", 160'(wl_q.size()), 160'(int'(len) + 1));
    i = 0;
    while (wl_q.size() > 0) begin
      wl = wl_q.pop_front();
      check("wlast_beat", 160'(wl), 160'(i == int'(len)));
      i++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.wd_strb = '0; bus.rd_ready = 1'b1;
    bresp_knob = 2'b00; rresp_knob = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 160'(bus.cmd_ready), 160'(1));
    check("rst_valids", 160'({bus.arvalid_m0, bus.awvalid_m0, bus.wvalid_m0, bus.bready_m0, bus.rready_m0}), 160'(0));
    check("rst_done", 160'({bus.done_pulse, bus.done_err, bus.wlast_m0}), 160'(0));
    check("rst_addr_len", 160'({bus.araddr_m0, bus.arlen_m0}), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);

    do_read(40'h1000, 8'd0, 1'b0, 1'b0);
    do_write(40'h2000, 8'd3, 16'hFFFF, 1'b1, 1'b0);
    do_write(40'h3000, 8'd15, 16'hFFFF, 1'b0, 1'b0);
    do_read(40'h3000, 8'd15, 1'b0, 1'b0);
    do_read(40'h3000, 8'd7, 1'b1, 1'b0);

    bresp_knob = 2'b10;
    do_write(40'h4000, 8'd0, 16'h00FF, 1'b0, 1'b1);
    bresp_knob = 2'b00;
    do_read(40'h4000, 8'd0, 1'b0, 1'b0);

    rresp_knob = 2'b10;
    do_read(40'h2000, 8'd3, 1'b0, 1'b1);
    rresp_knob = 2'b00;

`ifdef AXI_MASTER_4K_CHECK_EN
    start = done_cnt;
    send_cmd(1'b0, 40'hFF0, 8'd1);
    check("4k_no_arvalid", 160'(bus.arvalid_m0), 160'(0));
    check("4k_done", 160'({bus.done_pulse, bus.done_err}), 160'(2'b11));
    repeat (2) @(negedge clk);
    check("4k_done_count", 160'(done_cnt), 160'(start + 1));
    check("4k_no_ar", 160'(ar_q.size()), 160'(0));
`else
    do_read(40'hFF0, 8'd1, 1'b0, 1'b0);
`endif

    start = done_cnt;
    send_cmd(1'b1, 40'h5000, 8'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", 160'(bus.cmd_ready), 160'(1));
    check("midrst_outputs", 160'({bus.awvalid_m0, bus.wvalid_m0, bus.bready_m0, bus.done_pulse, bus.wlast_m0}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 160'(done_cnt), 160'(start));
    void'(aw_q.pop_front());
    do_read(40'h1008, 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
